// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the card-sequence result packer.
//   PACK_W      default number of result bits per packed word
//   LEN_W       width of length / hit-count fields for the default PACK_W
//   acc_state_t accumulator FSM state encoding
package seq_pkg;

  localparam int PACK_W = 8;
  localparam int LEN_W  = $clog2(PACK_W + 1);

  typedef enum logic [1:0] {
    ACC_EMPTY = 2'd0,  // no bits held
    ACC_FILL  = 2'd1,  // partial word, burst still running
    ACC_FULL  = 2'd2   // word complete or flush pending, waiting for the slot
  } acc_state_t;

endpackage

// File: rtl/seq_popcount.sv
// seq_popcount: purely combinational population count.
//   bits  : input word of W bits
//   count : number of ones in bits (0..W)
module seq_popcount #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  // Running sum chain; partial[k] holds the count of bits[k-1:0].
  logic [CW-1:0] partial [0:W];

  assign partial[0] = '0;

  for (genvar gi = 0; gi < W; gi++) begin : g_sum
    assign partial[gi+1] = partial[gi] + CW'(bits[gi]);
  end

  assign count = partial[W];

endmodule

// File: rtl/seq_result_packer.sv
// seq_result_packer: packs the checker's 1-bit result stream LSB-first into
// PACK_W-bit words, flushing a partial word at the end of every burst.
//   clk       : clock, all state on the rising edge
//   rst_n     : synchronous reset, active HIGH (name inherited from codebase)
//   in_valid  : result strobe (no backpressure possible upstream)
//   in_data   : result bit
//   out_ready : consumer accepts the current word
//   out_valid : word available in the output slot
//   out_data  : packed results, first result in bit 0, unused bits zero
//   out_len   : number of valid bits in out_data (1..PACK_W)
//   out_hits  : popcount of out_data
//   overflow  : sticky, a result was dropped because both stages were full
module seq_result_packer
  import seq_pkg::*;
#(
  parameter int PACK_W_P = seq_pkg::PACK_W,
  parameter int CNT_W    = $clog2(PACK_W_P + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                in_data,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [PACK_W_P-1:0] out_data,
  output logic [CNT_W-1:0]    out_len,
  output logic [CNT_W-1:0]    out_hits,
  output logic                overflow
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_W_P);

  acc_state_t          state_reg;
  logic [PACK_W_P-1:0] acc_reg;
  logic [CNT_W-1:0]    acc_cnt_reg;
  logic                prev_valid_reg;

  logic                slot_free;
  logic [PACK_W_P-1:0] acc_ins;
  logic [CNT_W-1:0]    cnt_inc;
  logic                load_en;
  logic [PACK_W_P-1:0] load_word;
  logic [CNT_W-1:0]    load_len;
  logic [CNT_W-1:0]    load_hits;
  logic                burst_end;

  // Slot can take a word this cycle if it is empty or being drained now.
  assign slot_free = !out_valid || out_ready;
  assign acc_ins   = acc_reg | (PACK_W_P'(in_data) << acc_cnt_reg);
  assign cnt_inc   = acc_cnt_reg + CNT_W'(1);
  assign burst_end = !in_valid && prev_valid_reg && (acc_cnt_reg != '0);

  // Select what (if anything) is loaded into the output slot this cycle.
  // A word completing right now bypasses the accumulator register.
  always_comb begin
    load_en   = 1'b0;
    load_word = acc_reg;
    load_len  = acc_cnt_reg;
    case (state_reg)
      ACC_FULL: begin
        load_en = slot_free;
      end
      default: begin
        if (in_valid) begin
          if (cnt_inc == FULL_CNT && slot_free) begin
            load_en   = 1'b1;
            load_word = acc_ins;
            load_len  = FULL_CNT;
          end
        end else if (burst_end && slot_free) begin
          load_en = 1'b1;
        end
      end
    endcase
  end

  // Hit count is taken from the word being loaded so the slot output is
  // purely registered.
  seq_popcount #(
    .W  (PACK_W_P),
    .CW (CNT_W)
  ) u_popcount (
    .bits  (load_word),
    .count (load_hits)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg      <= ACC_EMPTY;
      acc_reg        <= '0;
      acc_cnt_reg    <= '0;
      prev_valid_reg <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_len        <= '0;
      out_hits       <= '0;
      overflow       <= 1'b0;
    end else begin
      prev_valid_reg <= in_valid;

      // Output slot: reload wins over a plain drain in the same cycle.
      if (load_en) begin
        out_valid <= 1'b1;
        out_data  <= load_word;
        out_len   <= load_len;
        out_hits  <= load_hits;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state_reg)
        ACC_FULL: begin
          if (slot_free) begin
            // Accumulator moves to the slot; a simultaneous bit starts afresh.
            if (in_valid) begin
              acc_reg     <= PACK_W_P'(in_data);
              acc_cnt_reg <= CNT_W'(1);
              state_reg   <= ACC_FILL;
            end else begin
              acc_reg     <= '0;
              acc_cnt_reg <= '0;
              state_reg   <= ACC_EMPTY;
            end
          end else if (in_valid) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          if (in_valid) begin
            if (cnt_inc == FULL_CNT) begin
              if (slot_free) begin
                acc_reg     <= '0;
                acc_cnt_reg <= '0;
                state_reg   <= ACC_EMPTY;
              end else begin
                acc_reg     <= acc_ins;
                acc_cnt_reg <= cnt_inc;
                state_reg   <= ACC_FULL;
              end
            end else begin
              acc_reg     <= acc_ins;
              acc_cnt_reg <= cnt_inc;
              state_reg   <= ACC_FILL;
            end
          end else if (burst_end) begin
            if (slot_free) begin
              acc_reg     <= '0;
              acc_cnt_reg <= '0;
              state_reg   <= ACC_EMPTY;
            end else begin
              // Partial word waits in place, acc_cnt keeps its true length.
              state_reg <= ACC_FULL;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_result_packer.sv
// Scoreboard bench for seq_result_packer: stimulus pushes expected words,
// a monitor on the falling edge compares whatever the slot presents.
module tb_seq_result_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] out_len;
  logic [3:0] out_hits;
  logic       overflow;

  always #5 clk = ~clk;

  seq_result_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_hits  (out_hits),
    .overflow  (overflow)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] len;
    logic [3:0] hits;
  } word_t;

  word_t exp_q[$];
  word_t exp_w;
  int    checks = 0;
  int    passed = 0;
  int    words  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Monitor: every cycle the slot is valid it must show the oldest expected
  // word; the word retires when the consumer accepts it.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_word: got data=0x%0h len=%0d hits=%0d, want no word",
                   out_data, out_len, out_hits);
        end else begin
          exp_w = exp_q[0];
          if ({out_data, out_len, out_hits} === exp_w) begin
            passed++;
            if (out_ready) $display("word data=0x%0h len=%0d hits=%0d", out_data, out_len, out_hits);
          end else begin
            $display("FAIL word: got data=0x%0h len=%0d hits=%0d, want data=0x%0h len=%0d hits=%0d",
                     out_data, out_len, out_hits, exp_w.data, exp_w.len, exp_w.hits);
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            words++;
          end
        end
      end
    end
  end

  // Inputs change 1 time unit after the rising edge and are sampled at the next.
  task automatic drive(input logic v, input logic d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, bits[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    idle(2);
    rst_n = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_len",   out_len,   0);
    check("rst_out_hits",  out_hits,  0);
    check("rst_overflow",  overflow,  0);

    // Full word 1,0,1,1,0,0,0,1 -> 0x8D, valid for exactly one cycle.
    out_ready = 1'b1;
    exp_q.push_back('{data: 8'h8D, len: 4'd8, hits: 4'd4});
    burst(32'h8D, 8);
    check("full_latency", out_valid, 1);
    idle(1);
    check("full_one_cycle", out_valid, 0);
    idle(2);

    // Burst 1,1,0 then idle -> flush 0x03 len 3.
    exp_q.push_back('{data: 8'h03, len: 4'd3, hits: 4'd2});
    burst(32'h3, 3);
    check("flush_not_early", out_valid, 0);
    idle(1);
    check("flush_latency", out_valid, 1);
    idle(2);

    // Exactly 8 bits then idle: no empty flush word afterwards.
    exp_q.push_back('{data: 8'h96, len: 4'd8, hits: 4'd4});
    burst(32'h96, 8);
    idle(4);
    check("exact_no_empty_flush", out_valid, 0);
    check("exact_word_count", words, 3);

    // 16 back-to-back ones -> two 0xFF words.
    exp_q.push_back('{data: 8'hFF, len: 4'd8, hits: 4'd8});
    exp_q.push_back('{data: 8'hFF, len: 4'd8, hits: 4'd8});
    burst(32'hFF, 8);
    check("ones_first_valid", out_valid, 1);
    burst(32'hFF, 8);
    check("ones_second_valid", out_valid, 1);
    idle(3);
    check("ones_overflow", overflow, 0);
    check("ones_word_count", words, 5);

    // Backpressure: 17 alternating bits, the 17th is dropped.
    out_ready = 1'b0;
    exp_q.push_back('{data: 8'h55, len: 4'd8, hits: 4'd4});
    exp_q.push_back('{data: 8'h55, len: 4'd8, hits: 4'd4});
    burst(32'h15555, 17);
    check("bp_overflow_set", overflow, 1);
    check("bp_held_data", out_data, 8'h55);
    idle(2);
    check("bp_still_valid", out_valid, 1);
    // Accept, reload and new bit all in the same cycle; new bit flushes alone.
    exp_q.push_back('{data: 8'h01, len: 4'd1, hits: 4'd1});
    out_ready = 1'b1;
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    idle(3);
    check("bp_overflow_sticky", overflow, 1);
    check("bp_word_count", words, 8);

    // Reset mid-burst discards the partial word and clears everything.
    burst(32'h1F, 5);
    rst_n = 1'b1;
    drive(1'b1, 1'b1);
    rst_n = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data",  out_data,  0);
    check("mid_rst_out_len",   out_len,   0);
    check("mid_rst_out_hits",  out_hits,  0);
    check("mid_rst_overflow",  overflow,  0);
    idle(2);
    check("mid_rst_no_partial", out_valid, 0);
    exp_q.push_back('{data: 8'h01, len: 4'd3, hits: 4'd1});
    burst(32'h1, 3);
    idle(1);
    check("post_rst_flush", out_valid, 1);
    check("post_rst_len", out_len, 3);
    idle(3);
    check("final_word_count", words, 9);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seq_result_packer.md
# seq_result_packer

Downstream stage of the card-sequence checker. It takes the checker's 1-bit monotonic/non-monotonic result stream (`valid` + `data`, no backpressure) and packs results LSB-first into W-bit words. Words go out over a valid/ready port with length and hit count. A partial word is flushed at the end of each result burst, and results that cannot be buffered under backpressure are dropped and flagged.

## Interface
- `PACK_W`, 8: result bits per output word (≥2).
- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  synchronous, active-high reset (asserted = 1; port name kept per codebase convention).
- `in_valid`  input  1  result strobe from checker `out_valid`.
- `in_data`  input  1  result bit from checker `out_data` (1 = monotonic triple).
- `out_ready`  input  1  consumer accepts word.
- `out_valid`  output  1  word available.
- `out_data`  output  PACK_W  packed results, first result in bit 0; bits ≥ `out_len` are 0.
- `out_len`  output  $clog2(PACK_W+1)  number of valid bits, 1..PACK_W.
- `out_hits`  output  $clog2(PACK_W+1)  popcount of `out_data`.
- `overflow`  output  1  sticky; set when any result is dropped; cleared only by reset.

## Operation
- Two storage levels: accumulator (`acc`, `acc_cnt` 0..PACK_W) and output slot (`out_*` registers).
- `slot_free = !out_valid || out_ready`.
- Accumulator FSM states:
  - ACC_EMPTY: `acc_cnt` = 0.
  - ACC_FILL: 0 < `acc_cnt` < PACK_W, burst still active.
  - ACC_FULL: `acc_cnt` = PACK_W, or flush pending; waiting for the slot.
- Accepted bit: written to position `acc_cnt`; `acc_cnt` increments.
- Word completion: the PACK_W-th bit is accepted while `slot_free` = 1.
  - The slot loads the completed word directly: `out_len` = PACK_W.
  - Accumulator returns to ACC_EMPTY.
  - If `slot_free` = 0, go to ACC_FULL instead.
- Burst end: `in_valid` = 0 while the previous cycle had `in_valid` = 1, with `acc_cnt` > 0.
  - If `slot_free`, the partial word goes to the slot and the FSM goes to ACC_EMPTY.
  - Otherwise go to ACC_FULL with flush pending.
  - No word is produced when `acc_cnt` = 0 (an exact multiple of PACK_W).
- ACC_FULL:
  - When `slot_free`, the accumulator transfers to the slot.
  - An `in_valid` in the same cycle starts a new accumulator: bit at position 0, `acc_cnt` = 1, state ACC_FILL.
  - An `in_valid` while still blocked drops the bit and sets `overflow`.
- Slot:
  - Contents must stay stable while `out_valid` && !`out_ready`.
  - `out_valid` clears after acceptance unless reloaded in the same cycle.
- Arithmetic: `out_hits` is computed at load time from the word being loaded, so it is never combinational on the slot. No wrap: counters saturate by construction at PACK_W.
- Reset: applies in any state, mid-burst included. The accumulator is discarded and no partial word is emitted.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `out_len` = 0, `out_hits` = 0, `overflow` = 0; `acc` = 0, `acc_cnt` = 0, burst-history bit = 0, state ACC_EMPTY.
- Full word: `out_valid` rises the cycle after the cycle in which the PACK_W-th `in_valid` is sampled (latency 1).
- Flush: `out_valid` rises the cycle after the first `in_valid` = 0 cycle.
- Sustained throughput: one word every PACK_W cycles, with `out_ready` held high and no bubbles.
- Simultaneous slot acceptance, slot reload and new input bit in one cycle: all three take effect in that cycle.
- `overflow` rises the cycle after the dropped bit is sampled.

## Structure
- Package `seq_pkg`:
  - `PACK_W` default.
  - `LEN_W` = $clog2(PACK_W+1).
  - `acc_state_t` enum {ACC_EMPTY, ACC_FILL, ACC_FULL}.
- Sub-module `seq_popcount` (parameterised on width, purely combinational), used for `out_hits`.
- Top module holds the FSM, accumulator, slot and overflow flag (~150–250 lines).

## Test plan
- Bits 1,0,1,1,0,0,0,1 on 8 consecutive cycles, `out_ready` = 1 -> one cycle later `out_data` = 0x8D, `out_len` = 8, `out_hits` = 4, for exactly one cycle.
- Burst 1,1,0 then `in_valid` = 0 -> next cycle `out_data` = 0x03, `out_len` = 3, `out_hits` = 2.
- Exactly 8 bits then `in_valid` = 0 -> one full word only, no empty flush word.
- 16 back-to-back bits of all 1s, `out_ready` = 1 -> two words of 0xFF, 8 cycles apart, `out_hits` = 8 each, `overflow` = 0.
- `out_ready` = 0 while 17 bits of alternating 1,0 arrive:
  - First word 0x55 is held stable; the 17th bit is dropped and `overflow` = 1.
  - After raising `out_ready`, 0x55 then 0x55 are delivered in order; `overflow` stays 1.
- Reset asserted after 5 bits of a burst -> next cycle all outputs 0 and no partial word. A following 3-bit burst 1,0,0 yields `out_data` = 0x01, `out_len` = 3.
